// File: rtl/stopwatch_counter.sv
// Minutes:seconds BCD counter with a 1 Hz run path and synchronised,
// edge-detected adjust pulses from the adjustment block's clock domain.
module stopwatch_counter #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       pause,
    input  logic [1:0] adj_state,
    input  logic       sig_minute_adj,
    input  logic       sig_second_adj,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       rollover,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        MODE_RUN    = 2'b00,
        MODE_PAUSED = 2'b01,
        MODE_ADJUST = 2'b10
    } mode_e;

    if (SYNC_STAGES < 2) begin : g_bad_depth
        $error("stopwatch_counter: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] min_sync_q, min_sync_d;
    logic [SYNC_STAGES-1:0] sec_sync_q, sec_sync_d;
    logic                   min_dly_q, min_dly_d;
    logic                   sec_dly_q, sec_dly_d;

    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic       rollover_q, rollover_d;
    mode_e      mode_q, mode_d;

    logic       min_edge;
    logic       sec_edge;
    logic       run_inc;
    logic [8:0] min_next;
    logic [8:0] sec_next;

    // Advance a 00..59 BCD field; result is {carry_out, tens, ones}.
    function automatic logic [8:0] bcd60_inc(input logic [3:0] tens,
                                             input logic [3:0] ones);
        logic [8:0] res;
        res = {1'b0, tens, ones};
        if (ones == 4'd9) begin
            res[3:0] = 4'd0;
            if (tens == 4'd5) begin
                res[7:4] = 4'd0;
                res[8]   = 1'b1;
            end else begin
                res[7:4] = tens + 4'd1;
            end
        end else begin
            res[3:0] = ones + 4'd1;
        end
        return res;
    endfunction

    always_comb begin
        min_sync_d = {min_sync_q[SYNC_STAGES-2:0], sig_minute_adj};
        sec_sync_d = {sec_sync_q[SYNC_STAGES-2:0], sig_second_adj};
        min_dly_d  = min_sync_q[SYNC_STAGES-1];
        sec_dly_d  = sec_sync_q[SYNC_STAGES-1];
        min_edge   = min_sync_q[SYNC_STAGES-1] & ~min_dly_q;
        sec_edge   = sec_sync_q[SYNC_STAGES-1] & ~sec_dly_q;

        run_inc  = tick_1hz && (adj_state == 2'b00) && !pause;
        min_next = bcd60_inc(min_tens_q, min_ones_q);
        sec_next = bcd60_inc(sec_tens_q, sec_ones_q);

        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        rollover_d = 1'b0;

        // Edges seen while their field is unselected are consumed and lost.
        if (run_inc) begin
            {sec_tens_d, sec_ones_d} = sec_next[7:0];
            if (sec_next[8]) begin
                {min_tens_d, min_ones_d} = min_next[7:0];
                rollover_d               = min_next[8];
            end
        end else if (adj_state != 2'b00) begin
            if (adj_state[0] && min_edge) begin
                {min_tens_d, min_ones_d} = min_next[7:0];
            end
            if (adj_state[1] && sec_edge) begin
                {sec_tens_d, sec_ones_d} = sec_next[7:0];
            end
        end

        if (adj_state != 2'b00) begin
            mode_d = MODE_ADJUST;
        end else if (pause) begin
            mode_d = MODE_PAUSED;
        end else begin
            mode_d = MODE_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            min_sync_q <= '0;
            sec_sync_q <= '0;
            min_dly_q  <= 1'b0;
            sec_dly_q  <= 1'b0;
            min_tens_q <= '0;
            min_ones_q <= '0;
            sec_tens_q <= '0;
            sec_ones_q <= '0;
            rollover_q <= 1'b0;
            mode_q     <= MODE_RUN;
        end else begin
            min_sync_q <= min_sync_d;
            sec_sync_q <= sec_sync_d;
            min_dly_q  <= min_dly_d;
            sec_dly_q  <= sec_dly_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            rollover_q <= rollover_d;
            mode_q     <= mode_d;
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign rollover = rollover_q;
    assign mode     = mode_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: vector table, directed corner sequences and
// randomized stimulus checked against a time-in-seconds reference model.
module tb_stopwatch_counter;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       pause;
    logic [1:0] adj_state;
    logic       sig_minute_adj;
    logic       sig_second_adj;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       rollover;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: plain integers plus sampled input history.
    int         m_min = 0;
    int         m_sec = 0;
    bit         m_ro  = 1'b0;
    bit   [1:0] m_mode = 2'b00;
    bit         hist_min [0:N];
    bit         hist_sec [0:N];

    typedef struct {
        bit       rst;
        bit       tick;
        bit       pse;
        bit [1:0] adj;
        bit       smin;
        bit       ssec;
        int       em;
        int       es;
        bit       ero;
        bit [1:0] emode;
    } vec_t;

    vec_t vecs [14];

    stopwatch_counter #(.SYNC_STAGES(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .tick_1hz       (tick_1hz),
        .pause          (pause),
        .adj_state      (adj_state),
        .sig_minute_adj (sig_minute_adj),
        .sig_second_adj (sig_second_adj),
        .min_tens       (min_tens),
        .min_ones       (min_ones),
        .sec_tens       (sec_tens),
        .sec_ones       (sec_ones),
        .rollover       (rollover),
        .mode           (mode)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] pack(input int mm, input int ss,
                                         input bit ro, input bit [1:0] md);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), ro, md};
    endfunction

    function automatic logic [18:0] dut_pack();
        return {min_tens, min_ones, sec_tens, sec_ones, rollover, mode};
    endfunction

    task automatic check(input string name, input logic [18:0] got,
                         input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got mm:ss/ro/mode=%05h required %05h", name, got, exp);
        end
    endtask

    // An increment lands N edges after the first high sample of a rising level.
    task automatic model_edge();
        bit me, se;
        if (!reset) begin
            m_min = 0; m_sec = 0; m_ro = 1'b0; m_mode = 2'b00;
            for (int i = 0; i <= N; i++) begin
                hist_min[i] = 1'b0;
                hist_sec[i] = 1'b0;
            end
            return;
        end
        me = hist_min[N-1] && !hist_min[N];
        se = hist_sec[N-1] && !hist_sec[N];
        m_ro = 1'b0;
        if (tick_1hz && adj_state == 2'b00 && !pause) begin
            int t;
            t    = m_min * 60 + m_sec;
            m_ro = (t == 3599);
            t    = (t + 1) % 3600;
            m_min = t / 60;
            m_sec = t % 60;
        end else if (adj_state != 2'b00) begin
            if (me && adj_state[0]) m_min = (m_min + 1) % 60;
            if (se && adj_state[1]) m_sec = (m_sec + 1) % 60;
        end
        m_mode = (adj_state != 2'b00) ? 2'b10 : (pause ? 2'b01 : 2'b00);
        for (int i = N; i > 0; i--) begin
            hist_min[i] = hist_min[i-1];
            hist_sec[i] = hist_sec[i-1];
        end
        hist_min[0] = sig_minute_adj;
        hist_sec[0] = sig_second_adj;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("model", dut_pack(), pack(m_min, m_sec, m_ro, m_mode));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic pulse(input bit pm, input bit ps, input int n);
        repeat (n) begin
            sig_minute_adj = pm;
            sig_second_adj = ps;
            step();
            step();
            sig_minute_adj = 1'b0;
            sig_second_adj = 1'b0;
            step();
            step();
        end
    endtask

    initial begin
        int rem_m, rem_s;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0, 1, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 1, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 0, 1, 1'b0, 2'd1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0, 2, 1'b0, 2'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 0, 2, 1'b0, 2'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 0, 2, 1'b0, 2'd2};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0, 3, 1'b0, 2'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0, 4, 1'b0, 2'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 0, 4, 1'b0, 2'd2};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 0, 4, 1'b0, 2'd2};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1, 4, 1'b0, 2'd2};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1, 4, 1'b0, 2'd2};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1, 5, 1'b0, 2'd0};

        reset = 1'b0; tick_1hz = 1'b0; pause = 1'b0; adj_state = 2'b00;
        sig_minute_adj = 1'b0; sig_second_adj = 1'b0;
        #2;

        // Reset held for 3 edges with all inputs toggling.
        for (int i = 0; i < 3; i++) begin
            tick_1hz       = 1'($urandom);
            pause          = 1'($urandom);
            adj_state      = 2'($urandom);
            sig_minute_adj = 1'($urandom);
            sig_second_adj = 1'($urandom);
            step();
            check("reset_hold", dut_pack(), pack(0, 0, 1'b0, 2'b00));
        end
        tick_1hz = 1'b0; pause = 1'b0; adj_state = 2'b00;
        sig_minute_adj = 1'b0; sig_second_adj = 1'b0;
        reset = 1'b1;
        step();
        check("reset_release", dut_pack(), pack(0, 0, 1'b0, 2'b00));

        for (int i = 0; i < 14; i++) begin
            reset          = vecs[i].rst;
            tick_1hz       = vecs[i].tick;
            pause          = vecs[i].pse;
            adj_state      = vecs[i].adj;
            sig_minute_adj = vecs[i].smin;
            sig_second_adj = vecs[i].ssec;
            step();
            check($sformatf("vec%0d", i), dut_pack(),
                  pack(vecs[i].em, vecs[i].es, vecs[i].ero, vecs[i].emode));
        end
        tick_1hz = 1'b0; reset = 1'b1;

        // Run wrap from 59:58.
        do_reset();
        adj_state = 2'b11; pulse(1'b1, 1'b1, 58);
        adj_state = 2'b01; pulse(1'b1, 1'b0, 1);
        check("preload_5958", dut_pack(), pack(59, 58, 1'b0, 2'b10));
        adj_state = 2'b00; tick_1hz = 1'b1;
        step();
        check("wrap_5959", dut_pack(), pack(59, 59, 1'b0, 2'b00));
        step();
        check("wrap_0000", dut_pack(), pack(0, 0, 1'b1, 2'b00));
        tick_1hz = 1'b0;
        step();
        check("wrap_ro_clear", dut_pack(), pack(0, 0, 1'b0, 2'b00));

        // Second adjust from 12:59, 6-cycle pulse, no carry.
        do_reset();
        adj_state = 2'b11; pulse(1'b1, 1'b1, 12);
        adj_state = 2'b10; pulse(1'b0, 1'b1, 47);
        check("preload_1259", dut_pack(), pack(12, 59, 1'b0, 2'b10));
        sig_second_adj = 1'b1;
        step();
        step();
        check("secadj_wait", dut_pack(), pack(12, 59, 1'b0, 2'b10));
        step();
        check("secadj_nocarry", dut_pack(), pack(12, 0, 1'b0, 2'b10));
        repeat (3) step();
        sig_second_adj = 1'b0;
        repeat (4) step();
        check("secadj_once", dut_pack(), pack(12, 0, 1'b0, 2'b10));

        // Pause gating, then tick and minute pulse together in minute adjust.
        adj_state = 2'b00; pause = 1'b1; tick_1hz = 1'b1;
        repeat (5) step();
        check("pause_hold", dut_pack(), pack(12, 0, 1'b0, 2'b01));
        pause = 1'b0; adj_state = 2'b01; sig_minute_adj = 1'b1;
        step();
        tick_1hz = 1'b0;
        step();
        sig_minute_adj = 1'b0;
        step();
        check("adj_tick_ignored", dut_pack(), pack(13, 0, 1'b0, 2'b10));
        step();

        // Minute edge dropped in second-adjust, then both fields at once.
        adj_state = 2'b10; pulse(1'b1, 1'b0, 1);
        check("dropped_edge", dut_pack(), pack(13, 0, 1'b0, 2'b10));
        adj_state = 2'b11; pulse(1'b1, 1'b1, 9);
        adj_state = 2'b01; pulse(1'b1, 1'b0, 43);
        check("preload_0509", dut_pack(), pack(5, 9, 1'b0, 2'b10));
        adj_state = 2'b11; pulse(1'b1, 1'b1, 1);
        check("both_fields", dut_pack(), pack(6, 10, 1'b0, 2'b10));

        // Reset lands one edge after a second pulse rises; pulse still high at release.
        adj_state = 2'b10; sig_second_adj = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("midpulse_reset", dut_pack(), pack(0, 0, 1'b0, 2'b00));
        reset = 1'b1;
        step();
        step();
        check("midpulse_wait", dut_pack(), pack(0, 0, 1'b0, 2'b10));
        step();
        check("midpulse_inc", dut_pack(), pack(0, 1, 1'b0, 2'b10));
        sig_second_adj = 1'b0;
        repeat (3) step();

        // Randomized traffic against the model.
        rem_m = 0; rem_s = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rem_m == 0) begin
                sig_minute_adj = !sig_minute_adj;
                rem_m = $urandom_range(2, 7);
            end
            rem_m--;
            if (rem_s == 0) begin
                sig_second_adj = !sig_second_adj;
                rem_s = $urandom_range(2, 7);
            end
            rem_s--;
            if ($urandom_range(0, 15) == 0) adj_state = 2'($urandom);
            if ($urandom_range(0, 15) == 0) pause = 1'($urandom);
            tick_1hz = ($urandom_range(0, 2) == 0);
            reset    = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
